sargantana_icache_refill_buffer: RTL and testbench



---
 rtl/sargantana_icache_refill_buffer_pkg.sv | 24 ++
 rtl/sargantana_icache_refill_buffer_if.sv | 37 +++
 rtl/sargantana_icache_refill_buffer_line_assembler.sv | 23 ++
 rtl/sargantana_icache_refill_buffer.sv | 133 +++++++++++++
 tb/tb_sargantana_icache_refill_buffer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sargantana_icache_refill_buffer_pkg.sv
// Shared types and sizing for the icache line-fill path.
package sargantana_icache_pkg;
  localparam int ICACHE_DEPTH = 64;
  localparam int SET_WIDHT    = 256;
  localparam int ADDR_WIDHT   = $clog2(ICACHE_DEPTH);
  localparam int BEAT_WIDTH   = 64;
  localparam int NUM_WAYS     = 4;
  localparam int MAX_STALL    = 8;
  localparam int NBEATS       = SET_WIDHT / BEAT_WIDTH;
  localparam int BEAT_CNT_W   = $clog2(NBEATS);
  localparam int STALL_CNT_W  = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_DRAIN
  } refill_state_t;

  typedef struct packed {
    logic [ADDR_WIDHT-1:0] idx;
    logic [NUM_WAYS-1:0]   way;
  } refill_req_t;
endpackage

// File: rtl/sargantana_icache_refill_buffer_if.sv
// Command, L2 beat, lookup arbitration and way-port signals of the refill buffer.
interface sargantana_icache_refill_buffer_if;
  import sargantana_icache_pkg::*;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDHT-1:0] req_idx_i;
  logic [NUM_WAYS-1:0]   req_way_i;
  logic                  flush_i;
  logic                  beat_valid_i;
  logic                  beat_ready_o;
  logic [BEAT_WIDTH-1:0] beat_data_i;
  logic                  beat_last_i;
  logic                  beat_err_i;
  logic                  lookup_req_i;
  logic                  lookup_stall_o;
  logic [NUM_WAYS-1:0]   way_req_o;
  logic                  way_we_o;
  logic [ADDR_WIDHT-1:0] way_addr_o;
  logic [SET_WIDHT-1:0]  way_data_o;
  logic                  fill_done_o;
  logic                  fill_err_o;

  modport master (
    output req_valid_i, req_idx_i, req_way_i, flush_i,
    output beat_valid_i, beat_data_i, beat_last_i, beat_err_i, lookup_req_i,
    input  req_ready_o, beat_ready_o, lookup_stall_o, way_req_o, way_we_o,
    input  way_addr_o, way_data_o, fill_done_o, fill_err_o
  );

  modport slave (
    input  req_valid_i, req_idx_i, req_way_i, flush_i,
    input  beat_valid_i, beat_data_i, beat_last_i, beat_err_i, lookup_req_i,
    output req_ready_o, beat_ready_o, lookup_stall_o, way_req_o, way_we_o,
    output way_addr_o, way_data_o, fill_done_o, fill_err_o
  );
endinterface

// File: rtl/sargantana_icache_refill_buffer_line_assembler.sv
// Line buffer: NBEATS beat slots, one slot written per accepted beat.
module sargantana_icache_line_assembler
  import sargantana_icache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [BEAT_CNT_W-1:0] slot_i,
  input  logic [BEAT_WIDTH-1:0] data_i,
  output logic [SET_WIDHT-1:0]  line_o
);
  logic [NBEATS-1:0][BEAT_WIDTH-1:0] line_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q <= '0;
    end else if (we_i) begin
      line_q[slot_i] <= data_i;
    end
  end

  assign line_o = line_q;
endmodule

// File: rtl/sargantana_icache_refill_buffer.sv
// Icache refill buffer: collects an L2 line beat by beat, then writes it into one way,
// yielding the way port to lookups for at most MAX_STALL cycles.
module sargantana_icache_refill_buffer
  import sargantana_icache_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_i,
  sargantana_icache_refill_buffer_if.slave  bus
);
  refill_state_t          state_q, state_d;
  refill_req_t            req_q, req_d;
  logic [BEAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic [NUM_WAYS-1:0]    way_req_q, way_req_d;
  logic                   way_we_q, way_we_d;
  logic                   lookup_stall_q, lookup_stall_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;
  logic                   beat_hs, beat_wr, last_slot;

  assign bus.req_ready_o  = (state_q == ST_IDLE);
  assign bus.beat_ready_o = (state_q == ST_FILL) || (state_q == ST_DRAIN);
  assign beat_hs          = bus.beat_valid_i && bus.beat_ready_o;
  assign last_slot        = (cnt_q == BEAT_CNT_W'(NBEATS - 1));

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    stall_d        = stall_q;
    way_req_d      = '0;
    way_we_d       = 1'b0;
    lookup_stall_d = 1'b0;
    done_d         = 1'b0;
    ferr_d         = 1'b0;
    beat_wr        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          req_d   = '{idx: bus.req_idx_i, way: bus.req_way_i};
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (beat_hs) begin
          beat_wr = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          err_d   = err_q | bus.beat_err_i | (bus.beat_last_i != last_slot);
          // A flush that coincides with the final L2 beat has nothing left to drain.
          if (bus.flush_i) begin
            state_d = bus.beat_last_i ? ST_IDLE : ST_DRAIN;
          end else if (bus.beat_last_i && !last_slot) begin
            ferr_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (last_slot) begin
            stall_d = '0;
            state_d = ST_WRITE;
          end
        end else if (bus.flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_WRITE: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else if (err_q) begin
          ferr_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (!bus.lookup_req_i || stall_q == STALL_CNT_W'(MAX_STALL)) begin
          way_req_d      = req_q.way;
          way_we_d       = 1'b1;
          done_d         = 1'b1;
          lookup_stall_d = bus.lookup_req_i;
          state_d        = ST_IDLE;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (beat_hs && bus.beat_last_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      req_q          <= '0;
      cnt_q          <= '0;
      err_q          <= 1'b0;
      stall_q        <= '0;
      way_req_q      <= '0;
      way_we_q       <= 1'b0;
      lookup_stall_q <= 1'b0;
      done_q         <= 1'b0;
      ferr_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      stall_q        <= stall_d;
      way_req_q      <= way_req_d;
      way_we_q       <= way_we_d;
      lookup_stall_q <= lookup_stall_d;
      done_q         <= done_d;
      ferr_q         <= ferr_d;
    end
  end

  sargantana_icache_line_assembler u_line (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (beat_wr),
    .slot_i (cnt_q),
    .data_i (bus.beat_data_i),
    .line_o (bus.way_data_o)
  );

  assign bus.way_req_o      = way_req_q;
  assign bus.way_we_o       = way_we_q;
  assign bus.way_addr_o     = req_q.idx;
  assign bus.lookup_stall_o = lookup_stall_q;
  assign bus.fill_done_o    = done_q;
  assign bus.fill_err_o     = ferr_q;
endmodule

// File: tb/tb_sargantana_icache_refill_buffer.sv
// Directed bench for the icache refill buffer: vector table of refill scenarios plus
// hand-written reset/flush sequences.
module tb_sargantana_icache_refill_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  sargantana_icache_refill_buffer_if bus();

  sargantana_icache_refill_buffer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [3:0]  way;
    logic [55:0] tag;
    int          nb;
    int          last_at;
    int          err_at;
    int          flush_after;
    int          lk;
    int          exp_we_k;
    int          exp_err_k;
    bit          exp_forced;
  } vec_t;

  // Monitor results
  int           m_we_k, m_n_we, m_err_k, m_n_err, m_n_done, m_n_stall;
  logic [255:0] m_data;
  logic [3:0]   m_way;
  logic [5:0]   m_addr;
  bit           m_forced, m_done_with_we;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Clear all stimulus back to idle levels.
  task automatic quiet();
    bus.req_valid_i  = 1'b0;
    bus.flush_i      = 1'b0;
    bus.beat_valid_i = 1'b0;
    bus.beat_last_i  = 1'b0;
    bus.beat_err_i   = 1'b0;
  endtask

  // Issue a request and stream beats; returns right after the final handshake edge.
  task automatic run_fill(input logic [5:0] idx, input logic [3:0] way, input logic [55:0] tag,
                          input int nb, input int last_at, input int err_at,
                          input int flush_after, input bit flush_on_last);
    @(negedge clk);
    chk("req_ready_before_req", bus.req_ready_o, 1);
    bus.req_valid_i = 1'b1;
    bus.req_idx_i   = idx;
    bus.req_way_i   = way;
    @(posedge clk);
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      quiet();
      chk("beat_ready_in_fill", bus.beat_ready_o, 1);
      bus.beat_valid_i = 1'b1;
      bus.beat_data_i  = {tag, 8'(8'hA0 + b)};
      bus.beat_last_i  = (b == last_at);
      bus.beat_err_i   = (b == err_at);
      bus.flush_i      = flush_on_last && (b == nb - 1);
      @(posedge clk);
      if (b == flush_after) begin
        @(negedge clk);
        quiet();
        bus.flush_i = 1'b1;
        @(posedge clk);
      end
    end
  endtask

  // Observe kmax+1 cycles after the final handshake edge, holding lookup for lk cycles.
  task automatic monitor(input int lk, input int kmax);
    m_we_k = -1; m_n_we = 0; m_err_k = -1; m_n_err = 0; m_n_done = 0; m_n_stall = 0;
    m_data = '0; m_way = '0; m_addr = '0; m_forced = 1'b0; m_done_with_we = 1'b0;
    for (int k = 0; k <= kmax; k++) begin
      @(negedge clk);
      quiet();
      if (bus.way_we_o) begin
        m_n_we++;
        m_we_k         = k;
        m_data         = bus.way_data_o;
        m_way          = bus.way_req_o;
        m_addr         = bus.way_addr_o;
        m_forced       = bus.lookup_stall_o;
        m_done_with_we = bus.fill_done_o;
      end
      if (bus.fill_err_o) begin
        m_n_err++;
        m_err_k = k;
      end
      if (bus.fill_done_o) m_n_done++;
      if (bus.lookup_stall_o) m_n_stall++;
      bus.lookup_req_i = (k + 1 <= lk);
      if (k != kmax) @(posedge clk);
    end
    bus.lookup_req_i = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready_o, 1);
    chk({tag, "_beat_ready"}, bus.beat_ready_o, 0);
    chk({tag, "_way_req"}, bus.way_req_o, 0);
    chk({tag, "_way_we"}, bus.way_we_o, 0);
    chk({tag, "_lookup_stall"}, bus.lookup_stall_o, 0);
    chk({tag, "_fill_done"}, bus.fill_done_o, 0);
    chk({tag, "_fill_err"}, bus.fill_err_o, 0);
  endtask

  vec_t         vecs[9];
  logic [255:0] exp_line;

  initial begin
    quiet();
    bus.lookup_req_i = 1'b0;
    bus.req_idx_i    = '0;
    bus.req_way_i    = '0;
    bus.beat_data_i  = '0;

    //        idx    way     tag            nb last err flush lk  we_k err_k forced
    vecs[0] = '{6'd5,  4'b0010, 56'h11223344556677, 4, 3, -1, -1, 0,  1, -1, 0};
    vecs[1] = '{6'd5,  4'b0010, 56'h11223344556677, 4, 3, -1, -1, 20, 9, -1, 1};
    vecs[2] = '{6'd63, 4'b1000, 56'hDEADBEEFCAFE01, 4, 3, -1, -1, 3,  4, -1, 0};
    vecs[3] = '{6'd9,  4'b0100, 56'h0F0F0F0F0F0F0F, 4, 3,  2, -1, 0, -1,  1, 0};
    vecs[4] = '{6'd9,  4'b0100, 56'h0F0F0F0F0F0F0F, 2, 1, -1, -1, 0, -1,  0, 0};
    vecs[5] = '{6'd9,  4'b0100, 56'h0F0F0F0F0F0F0F, 4, -1, -1, -1, 0, -1, 1, 0};
    vecs[6] = '{6'd12, 4'b0001, 56'h55555555555555, 4, 3, -1,  1, 0, -1, -1, 0};
    vecs[7] = '{6'd0,  4'b0001, 56'h0123456789ABCD, 4, 3, -1, -1, 8,  9, -1, 0};
    vecs[8] = '{6'd33, 4'b1000, 56'hFEDCBA98765432, 4, 3, -1, -1, 9,  9, -1, 1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_values("reset");
    bus.beat_valid_i = 1'b1;
    @(negedge clk);
    chk("idle_beat_not_ready", bus.beat_ready_o, 0);
    chk("idle_beat_no_fill", bus.req_ready_o, 1);
    quiet();

    foreach (vecs[i]) begin
      run_fill(vecs[i].idx, vecs[i].way, vecs[i].tag, vecs[i].nb, vecs[i].last_at,
               vecs[i].err_at, vecs[i].flush_after, 1'b0);
      monitor(vecs[i].lk, 12);
      chk($sformatf("v%0d_n_we", i), m_n_we, (vecs[i].exp_we_k >= 0) ? 1 : 0);
      chk($sformatf("v%0d_we_k", i), m_we_k, vecs[i].exp_we_k);
      chk($sformatf("v%0d_n_done", i), m_n_done, (vecs[i].exp_we_k >= 0) ? 1 : 0);
      chk($sformatf("v%0d_n_err", i), m_n_err, (vecs[i].exp_err_k >= 0) ? 1 : 0);
      chk($sformatf("v%0d_err_k", i), m_err_k, vecs[i].exp_err_k);
      chk($sformatf("v%0d_n_stall", i), m_n_stall, vecs[i].exp_forced ? 1 : 0);
      if (vecs[i].exp_we_k >= 0) begin
        for (int b = 0; b < 4; b++) exp_line[b*64 +: 64] = {vecs[i].tag, 8'(8'hA0 + b)};
        chk($sformatf("v%0d_data", i), m_data, exp_line);
        chk($sformatf("v%0d_way", i), m_way, vecs[i].way);
        chk($sformatf("v%0d_addr", i), m_addr, vecs[i].idx);
        chk($sformatf("v%0d_forced", i), m_forced, vecs[i].exp_forced);
        chk($sformatf("v%0d_done_with_we", i), m_done_with_we, 1);
      end
      chk($sformatf("v%0d_ready_after", i), bus.req_ready_o, 1);
    end

    // Flush in WRITE beats a same-cycle write opportunity.
    run_fill(6'd7, 4'b0100, 56'hABABABABABABAB, 4, 3, -1, -1, 1'b0);
    @(negedge clk);
    quiet();
    bus.lookup_req_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.lookup_req_i = 1'b0;
    bus.flush_i      = 1'b1;
    @(posedge clk);
    monitor(0, 10);
    chk("wflush_n_we", m_n_we, 0);
    chk("wflush_n_done", m_n_done, 0);
    chk("wflush_n_err", m_n_err, 0);
    chk("wflush_ready", bus.req_ready_o, 1);

    // Flush together with the final beat drops the line silently.
    run_fill(6'd3, 4'b0010, 56'h77777777777777, 4, 3, -1, -1, 1'b1);
    monitor(0, 10);
    chk("lastflush_n_we", m_n_we, 0);
    chk("lastflush_n_done", m_n_done, 0);
    chk("lastflush_n_err", m_n_err, 0);
    chk("lastflush_ready", bus.req_ready_o, 1);

    // Reset while a write is held off by lookups.
    run_fill(6'd21, 4'b0001, 56'h99999999999999, 4, 3, -1, -1, 1'b0);
    @(negedge clk);
    quiet();
    bus.lookup_req_i = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_values("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.lookup_req_i = 1'b0;
    monitor(0, 14);
    chk("midrst_n_we", m_n_we, 0);
    chk("midrst_n_done", m_n_done, 0);
    chk("midrst_n_err", m_n_err, 0);
    chk("midrst_ready", bus.req_ready_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
